tdm_ingress_mux: RTL

- Upstream feeder for the 10x10 BPU's time-multiplexed serial ingress.
- Accepts NUM_PORTS independent byte streams with a valid/ready handshake and buffers each stream in its own FIFO.
- Drives the BPU's single shared input_wire / input_new_packet / input_data lane, one port per TDM slot.
- Its slot counter runs in lock-step with the BPU's free-running 8-bit input_sel counter; both leave reset on the same edge.

---
 rtl/tdm_ingress_mux.sv | 120 ++++++++++++
 1 files changed

// File: rtl/tdm_ingress_mux.sv
// tdm_ingress_mux: per-port byte FIFOs drained onto one shared serial lane,
// one port per TDM slot, slot counter in lock-step with the BPU input_sel.
module tdm_ingress_mux #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_PORTS   = 10,
  parameter int SLOT_PERIOD = 256,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            in_valid,
  output logic [NUM_PORTS-1:0]            in_ready,
  input  logic [NUM_PORTS-1:0]            in_sop,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  output logic                            output_wire,
  output logic                            output_new_packet,
  output logic [DATA_WIDTH-1:0]           output_data,
  output logic [7:0]                      slot_cnt,
  output logic [NUM_PORTS-1:0]            fifo_full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + 1;
  localparam logic [7:0]    SLOT_LAST = 8'(SLOT_PERIOD - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  logic [7:0]            slot_q;
  logic [7:0]            slot_d;
  logic [EW-1:0]         mem_q    [NUM_PORTS][FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q [NUM_PORTS];
  logic [AW-1:0]         rd_ptr_q [NUM_PORTS];
  logic [CW-1:0]         cnt_q    [NUM_PORTS];
  logic [NUM_PORTS-1:0]  full;
  logic [NUM_PORTS-1:0]  push;
  logic [NUM_PORTS-1:0]  pop;
  logic [EW-1:0]         head;
  logic                  wire_d;
  logic                  np_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  wire_q;
  logic                  np_q;
  logic [DATA_WIDTH-1:0] data_q;

  // Slot counter next value, wrapping at the BPU counter modulus.
  always_comb begin
    slot_d = (slot_q == SLOT_LAST) ? 8'd0 : slot_q + 8'd1;
  end

  // Flow control from registered counts; pop only the port owning slot_d.
  always_comb begin
    full = '0;
    push = '0;
    pop  = '0;
    head = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      full[p] = (cnt_q[p] == FULL_CNT);
      push[p] = in_valid[p] && !full[p];
      if (slot_d == 8'(p) && cnt_q[p] != '0) begin
        pop[p] = 1'b1;
        head   = mem_q[p][rd_ptr_q[p]];
      end
    end
  end

  // Lane value for the slot about to start; idle or empty slots show zero.
  always_comb begin
    wire_d = 1'b0;
    np_d   = 1'b0;
    data_d = '0;
    if (|pop) begin
      wire_d = 1'b1;
      np_d   = head[EW-1];
      data_d = head[DATA_WIDTH-1:0];
    end
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push[p]) begin
        mem_q[p][wr_ptr_q[p]] <=
          {in_sop[p], in_data[p*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

  // Slot counter, FIFO pointers/counts and registered lane outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= '0;
      wire_q <= 1'b0;
      np_q   <= 1'b0;
      data_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        cnt_q[p]    <= '0;
      end
    end else begin
      slot_q <= slot_d;
      wire_q <= wire_d;
      np_q   <= np_d;
      data_q <= data_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (push[p]) wr_ptr_q[p] <= wr_ptr_q[p] + AW'(1);
        if (pop[p])  rd_ptr_q[p] <= rd_ptr_q[p] + AW'(1);
        cnt_q[p] <= cnt_q[p] + CW'(push[p]) - CW'(pop[p]);
      end
    end
  end

  assign slot_cnt          = slot_q;
  assign output_wire       = wire_q;
  assign output_new_packet = np_q;
  assign output_data       = data_q;
  assign fifo_full         = full;
  assign in_ready          = ~full;

endmodule
